lfsr_seq_checker: RTL and testbench
===================================

Name: lfsr_seq_checker

Overview:
- Receive-side checker for the 8-bit LFSR random stream produced by the team's random generator.
- Synchronises to an incoming byte stream by self-seeding from received samples. Declares lock after a run of correct predictions, then free-runs its own LFSR ("flywheel") so single errors do not propagate.
- Counts mismatches while locked and drops lock after a run of consecutive misses.
- Sits on the consumer side of any link or loopback carrying the generator output, for BIST and link checking.

Parameters:
LOCK_CNT, 4, consecutive correct predictions required to declare lock (1..15)
LOSS_CNT, 3, consecutive mispredictions while locked that force loss of lock (1..15)
ERR_W, 16, width of the saturating error counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  in_data carries a stream sample this cycle
in_data  in  8  received LFSR byte
clr_err  in  1  synchronous clear of err_cnt
locked  out  1  checker is locked to the stream
err_pulse  out  1  one-cycle pulse per mismatching sample while locked
err_cnt  out  ERR_W  saturating count of mismatches while locked
state_o  out  2  current state: 0 SEEK, 1 TRACK, 2 LOCKED

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state SEEK; ref_q=0x00; match_cnt=0; miss_cnt=0. Outputs locked=0, err_pulse=0, err_cnt=0, state_o=0.
- Prediction function: nxt(x) = {x[6:0], x[5]^x[3]^x[2]^x[0]}. This recurrence is identical to the generator's.
- Only cycles with in_valid=1 advance the checker. With in_valid=0, all state holds and err_pulse=0.
- SEEK:
  - On a valid sample: ref_q<=in_data, match_cnt<=0, go to TRACK.
- TRACK:
  - Valid sample with in_data==nxt(ref_q): ref_q<=in_data, match_cnt+1.
  - When the incremented count equals LOCK_CNT: go to LOCKED, miss_cnt<=0.
  - Valid sample that mismatches: ref_q<=in_data (re-seed), match_cnt<=0, stay in TRACK.
  - No errors are counted in TRACK.
- LOCKED:
  - Every valid sample: ref_q<=nxt(ref_q) (flywheel, not in_data).
  - Match: miss_cnt<=0.
  - Mismatch: err_pulse=1 next cycle; err_cnt+1 saturating at all-ones; miss_cnt+1.
  - When miss_cnt reaches LOSS_CNT: go to SEEK, locked<=0, match_cnt<=0. This final mismatch is still counted in err_cnt.
- Timing: locked, err_pulse, err_cnt and state_o are registered. Each updates in the cycle after the edge that sampled the triggering in_valid.
- clr_err:
  - Has priority over a simultaneous error: err_cnt becomes 0 and that error is not counted.
  - err_pulse still fires.
- Saturation: at all-ones, err_cnt holds; err_pulse continues to fire.
- All-zero stream: nxt(0x00)=0x00, so a constant-zero stream will lock. This is detected only by the optional feature.
- Reset asserted mid-stream returns all state to reset values immediately. Relock needs 1+LOCK_CNT valid samples after release.

Optional Feature:
STUCK_DETECT_EN
- Defined:
  - Adds output stuck (1 bit, reset 0).
  - In TRACK or LOCKED, a valid in_data==0x00 forces state SEEK, sets stuck=1 and does not count an error.
  - stuck clears on the next valid nonzero sample.
  - In SEEK, a zero sample is ignored: no transition to TRACK.
- Undefined: no stuck port; zero samples are treated like any other value.

Test Plan:
- Reset, then valid stream 0x01,0x03,0x07,0x0E,0x1C (LOCK_CNT=4) -> locked=1 in the cycle after 0x1C is sampled; err_cnt=0.
- Locked on 0x1C; send 0x38, then 0xFF in place of 0x70, then 0xE1 -> one err_pulse, err_cnt=1, locked stays 1 (flywheel predicts 0xE1).
- Locked; send 3 consecutive wrong bytes 0xAA (LOSS_CNT=3) -> err_cnt=3, locked=0 and state_o=0 after the third; relock on a good 5-sample run.
- In TRACK after 0x01,0x03, send 0x55 then 0x55's true successor run of 4 -> re-seed on 0x55, locked after 4 further matches, err_cnt=0.
- err_cnt at 16'hFFFE, two errors with clr_err asserted on the second -> err_cnt 0xFFFF, then 0x0000; both err_pulse fire.
- STUCK_DETECT_EN defined, locked, send 0x00 -> stuck=1, state_o=0, err_cnt unchanged; next sample 0x01 -> stuck=0, state TRACK.

Source files
------------

// File: rtl/lfsr_seq_checker.sv
// lfsr_seq_checker: receive-side checker for the 8-bit LFSR byte stream.
// Seeds itself from received samples, locks after LOCK_CNT good predictions,
// then flywheels its own LFSR and counts mismatches until LOSS_CNT consecutive misses.
// Optional build macro STUCK_DETECT_EN adds the 'stuck' output and all-zero stream detection.
module lfsr_seq_checker #(
   parameter int unsigned LOCK_CNT = 4,
   parameter int unsigned LOSS_CNT = 3,
   parameter int unsigned ERR_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   input  logic             clr_err,
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_cnt,
`ifdef STUCK_DETECT_EN
   output logic             stuck,
`endif
   output logic [1:0]       state_o
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      SEEK   = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [7:0]         ref_q, ref_d;
   logic [CNT_W-1:0]   match_cnt, match_cnt_d;
   logic [CNT_W-1:0]   miss_cnt, miss_cnt_d;
   logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
   logic               err_pulse_q, err_pulse_d;
   logic               locked_q, locked_d;
   logic               err_hit;
   logic [7:0]         pred;
   logic [CNT_W-1:0]   match_inc;
   logic [CNT_W-1:0]   miss_inc;
`ifdef STUCK_DETECT_EN
   logic               stuck_q, stuck_d;
`endif

   // Generator recurrence: shift left, feedback from taps 5,3,2,0
   function automatic logic [7:0] nxt(input logic [7:0] x);
      return {x[6:0], x[5] ^ x[3] ^ x[2] ^ x[0]};
   endfunction

   assign pred      = nxt(ref_q);
   assign match_inc = match_cnt + CNT_W'(1);
   assign miss_inc  = miss_cnt + CNT_W'(1);

   // State register and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= SEEK;
         ref_q       <= 8'h00;
         match_cnt   <= '0;
         miss_cnt    <= '0;
         err_cnt_q   <= '0;
         err_pulse_q <= 1'b0;
         locked_q    <= 1'b0;
`ifdef STUCK_DETECT_EN
         stuck_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ref_q       <= ref_d;
         match_cnt   <= match_cnt_d;
         miss_cnt    <= miss_cnt_d;
         err_cnt_q   <= err_cnt_d;
         err_pulse_q <= err_pulse_d;
         locked_q    <= locked_d;
`ifdef STUCK_DETECT_EN
         stuck_q     <= stuck_d;
`endif
      end
   end

   // Next-state, reference LFSR, counters and output next values
   always_comb begin
      state_d     = state_q;
      ref_d       = ref_q;
      match_cnt_d = match_cnt;
      miss_cnt_d  = miss_cnt;
      err_hit     = 1'b0;
`ifdef STUCK_DETECT_EN
      stuck_d     = stuck_q;
`endif

      if (in_valid) begin
         case (state_q)
            SEEK: begin
               ref_d       = in_data;
               match_cnt_d = '0;
               state_d     = TRACK;
            end
            TRACK: begin
               // Track the received bytes either way; a mismatch simply re-seeds
               ref_d = in_data;
               if (in_data == pred) begin
                  match_cnt_d = match_inc;
                  if (match_inc == CNT_W'(LOCK_CNT)) begin
                     state_d    = LOCKED;
                     miss_cnt_d = '0;
                  end
               end else begin
                  match_cnt_d = '0;
               end
            end
            LOCKED: begin
               // Flywheel: advance our own LFSR, ignore the received value
               ref_d = pred;
               if (in_data == pred) begin
                  miss_cnt_d = '0;
               end else begin
                  err_hit    = 1'b1;
                  miss_cnt_d = miss_inc;
                  if (miss_inc == CNT_W'(LOSS_CNT)) begin
                     state_d     = SEEK;
                     match_cnt_d = '0;
                  end
               end
            end
            default: begin
               state_d = SEEK;
            end
         endcase

`ifdef STUCK_DETECT_EN
         // A zero byte would lock on the degenerate all-zero sequence; treat it as stuck
         if (in_data == 8'h00) begin
            if (state_q == SEEK) begin
               state_d     = state_q;
               ref_d       = ref_q;
               match_cnt_d = match_cnt;
            end else begin
               state_d     = SEEK;
               stuck_d     = 1'b1;
               err_hit     = 1'b0;
               match_cnt_d = '0;
               miss_cnt_d  = '0;
            end
         end else begin
            stuck_d = 1'b0;
         end
`endif
      end

      // Clear wins over a same-cycle error; counter saturates at all-ones
      if (clr_err) begin
         err_cnt_d = '0;
      end else if (err_hit && (err_cnt_q != {ERR_W{1'b1}})) begin
         err_cnt_d = err_cnt_q + ERR_W'(1);
      end else begin
         err_cnt_d = err_cnt_q;
      end

      err_pulse_d = err_hit;
      locked_d    = (state_d == LOCKED);
   end

   assign locked    = locked_q;
   assign err_pulse = err_pulse_q;
   assign err_cnt   = err_cnt_q;
   assign state_o   = state_q;
`ifdef STUCK_DETECT_EN
   assign stuck     = stuck_q;
`endif

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// tb_lfsr_seq_checker: directed vector bench for lfsr_seq_checker.
// A second instance with a 3-bit error counter exercises saturation on the same stream.
// Build with STUCK_DETECT_EN defined to also cover the stuck-stream detection.
module tb_lfsr_seq_checker;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        clr_err;
   logic        locked;
   logic        err_pulse;
   logic [15:0] err_cnt;
   logic [1:0]  state_o;
   logic        s_locked;
   logic        s_err_pulse;
   logic [2:0]  s_err_cnt;
   logic [1:0]  s_state_o;
`ifdef STUCK_DETECT_EN
   logic        stuck;
   logic        s_stuck;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   lfsr_seq_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .clr_err   (clr_err),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_cnt   (err_cnt),
`ifdef STUCK_DETECT_EN
      .stuck     (stuck),
`endif
      .state_o   (state_o)
   );

   lfsr_seq_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(3)) dut_sat (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .clr_err   (clr_err),
      .locked    (s_locked),
      .err_pulse (s_err_pulse),
      .err_cnt   (s_err_cnt),
`ifdef STUCK_DETECT_EN
      .stuck     (s_stuck),
`endif
      .state_o   (s_state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic        clr;
      logic        lk;
      logic        pl;
      logic [15:0] err;
      logic [2:0]  sat;
      logic [1:0]  st;
   } vec_t;

   vec_t tab1[$];
   vec_t tab2[$];

   function automatic vec_t mk(input logic v, input logic [7:0] d, input logic clr,
                               input logic lk, input logic pl, input logic [15:0] err,
                               input logic [2:0] sat, input logic [1:0] st);
      vec_t t;
      t.v = v; t.d = d; t.clr = clr; t.lk = lk; t.pl = pl; t.err = err; t.sat = sat; t.st = st;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input string tag, input int idx, input vec_t t);
      @(negedge clk);
      in_valid = t.v;
      in_data  = t.d;
      clr_err  = t.clr;
      @(posedge clk);
      #1;
      chk($sformatf("%s[%0d].locked", tag, idx),    32'(locked),    32'(t.lk));
      chk($sformatf("%s[%0d].err_pulse", tag, idx), 32'(err_pulse), 32'(t.pl));
      chk($sformatf("%s[%0d].err_cnt", tag, idx),   32'(err_cnt),   32'(t.err));
      chk($sformatf("%s[%0d].state_o", tag, idx),   32'(state_o),   32'(t.st));
      chk($sformatf("%s[%0d].sat_err_cnt", tag, idx), 32'(s_err_cnt), 32'(t.sat));
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".locked"},    32'(locked),    32'd0);
      chk({tag, ".err_pulse"}, 32'(err_pulse), 32'd0);
      chk({tag, ".err_cnt"},   32'(err_cnt),   32'd0);
      chk({tag, ".state_o"},   32'(state_o),   32'd0);
      chk({tag, ".sat_err"},   32'(s_err_cnt), 32'd0);
`ifdef STUCK_DETECT_EN
      chk({tag, ".stuck"},     32'(stuck),     32'd0);
`endif
   endtask

   initial begin
      // Lock on 01..1C, single error with flywheel, idle hold, loss of lock, relock, clear
      //                 v  data   clr lk pl err  sat st
      tab1.push_back(mk(1, 8'h01, 0, 0, 0, 16'd0, 3'd0, 2'd1));
      tab1.push_back(mk(1, 8'h03, 0, 0, 0, 16'd0, 3'd0, 2'd1));
      tab1.push_back(mk(1, 8'h07, 0, 0, 0, 16'd0, 3'd0, 2'd1));
      tab1.push_back(mk(1, 8'h0E, 0, 0, 0, 16'd0, 3'd0, 2'd1));
      tab1.push_back(mk(1, 8'h1C, 0, 1, 0, 16'd0, 3'd0, 2'd2));
      tab1.push_back(mk(1, 8'h38, 0, 1, 0, 16'd0, 3'd0, 2'd2));
      tab1.push_back(mk(1, 8'hFF, 0, 1, 1, 16'd1, 3'd1, 2'd2));
      tab1.push_back(mk(1, 8'hE1, 0, 1, 0, 16'd1, 3'd1, 2'd2));
      tab1.push_back(mk(0, 8'hAA, 0, 1, 0, 16'd1, 3'd1, 2'd2));
      tab1.push_back(mk(1, 8'hAA, 0, 1, 1, 16'd2, 3'd2, 2'd2));
      tab1.push_back(mk(1, 8'hAA, 0, 1, 1, 16'd3, 3'd3, 2'd2));
      tab1.push_back(mk(1, 8'hAA, 0, 0, 1, 16'd4, 3'd4, 2'd0));
      tab1.push_back(mk(1, 8'h09, 0, 0, 0, 16'd4, 3'd4, 2'd1));
      tab1.push_back(mk(1, 8'h12, 0, 0, 0, 16'd4, 3'd4, 2'd1));
      tab1.push_back(mk(1, 8'h24, 0, 0, 0, 16'd4, 3'd4, 2'd1));
      tab1.push_back(mk(1, 8'h48, 0, 0, 0, 16'd4, 3'd4, 2'd1));
      tab1.push_back(mk(1, 8'h91, 0, 1, 0, 16'd4, 3'd4, 2'd2));
      tab1.push_back(mk(1, 8'h23, 1, 1, 0, 16'd0, 3'd0, 2'd2));

      // Re-seed in TRACK on 0x55, lock, then drive the 3-bit counter into saturation
      tab2.push_back(mk(1, 8'h01, 0, 0, 0, 16'd0, 3'd0, 2'd1));
      tab2.push_back(mk(1, 8'h03, 0, 0, 0, 16'd0, 3'd0, 2'd1));
      tab2.push_back(mk(1, 8'h55, 0, 0, 0, 16'd0, 3'd0, 2'd1));
      tab2.push_back(mk(1, 8'hAA, 0, 0, 0, 16'd0, 3'd0, 2'd1));
      tab2.push_back(mk(1, 8'h54, 0, 0, 0, 16'd0, 3'd0, 2'd1));
      tab2.push_back(mk(1, 8'hA9, 0, 0, 0, 16'd0, 3'd0, 2'd1));
      tab2.push_back(mk(1, 8'h53, 0, 1, 0, 16'd0, 3'd0, 2'd2));
      tab2.push_back(mk(1, 8'hAA, 0, 1, 1, 16'd1, 3'd1, 2'd2));
      tab2.push_back(mk(1, 8'hAA, 0, 1, 1, 16'd2, 3'd2, 2'd2));
      tab2.push_back(mk(1, 8'h9F, 0, 1, 0, 16'd2, 3'd2, 2'd2));
      tab2.push_back(mk(1, 8'hAA, 0, 1, 1, 16'd3, 3'd3, 2'd2));
      tab2.push_back(mk(1, 8'hAA, 0, 1, 1, 16'd4, 3'd4, 2'd2));
      tab2.push_back(mk(1, 8'hFD, 0, 1, 0, 16'd4, 3'd4, 2'd2));
      tab2.push_back(mk(1, 8'hAA, 0, 1, 1, 16'd5, 3'd5, 2'd2));
      tab2.push_back(mk(1, 8'hAA, 0, 1, 1, 16'd6, 3'd6, 2'd2));
      tab2.push_back(mk(1, 8'hE8, 0, 1, 0, 16'd6, 3'd6, 2'd2));
      tab2.push_back(mk(1, 8'hAA, 0, 1, 1, 16'd7, 3'd7, 2'd2));
      tab2.push_back(mk(1, 8'hA0, 0, 1, 0, 16'd7, 3'd7, 2'd2));
      tab2.push_back(mk(1, 8'hAA, 0, 1, 1, 16'd8, 3'd7, 2'd2));
      tab2.push_back(mk(1, 8'hAA, 1, 1, 1, 16'd0, 3'd0, 2'd2));
      tab2.push_back(mk(1, 8'h07, 0, 1, 0, 16'd0, 3'd0, 2'd2));

      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      clr_err  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset("reset");
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tab1[i]) run_vec("t1", i, tab1[i]);

      // Mid-stream asynchronous reset takes effect without a clock edge
      @(negedge clk);
      in_valid = 1'b0;
      clr_err  = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset("midrst");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tab2[i]) run_vec("t2", i, tab2[i]);

`ifdef STUCK_DETECT_EN
      // Zero byte while locked: back to SEEK, flagged stuck, no error counted
      run_vec("stk", 0, mk(1, 8'h00, 0, 0, 0, 16'd0, 3'd0, 2'd0));
      chk("stk0.stuck", 32'(stuck), 32'd1);
      // Zero byte in SEEK is ignored
      run_vec("stk", 1, mk(1, 8'h00, 0, 0, 0, 16'd0, 3'd0, 2'd0));
      chk("stk1.stuck", 32'(stuck), 32'd1);
      // Nonzero sample clears stuck and starts tracking
      run_vec("stk", 2, mk(1, 8'h01, 0, 0, 0, 16'd0, 3'd0, 2'd1));
      chk("stk2.stuck", 32'(stuck), 32'd0);
`endif

      @(negedge clk);
      in_valid = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
